// File: rtl/usr_reg_cmd_decoder_pkg.sv
// Shared definitions for the MCU user-register command decoder: field layout,
// opcodes, LED modes and FSM states.
package usr_reg_cmd_decoder_pkg;

    localparam int CMD_W   = 16;
    localparam int SEQ_BIT = 15;
    localparam int OP_MSB  = 14;
    localparam int OP_LSB  = 12;
    localparam int ARG_W   = 12;

    localparam logic [2:0] OP_NOP   = 3'd0;
    localparam logic [2:0] OP_LED   = 3'd1;
    localparam logic [2:0] OP_BLINK = 3'd2;
    localparam logic [2:0] OP_PULSE = 3'd3;
    localparam logic [2:0] OP_USR   = 3'd4;

    // Bit order matches usr_reg: [15]=seq, [14:12]=op, [11:0]=arg.
    typedef struct packed {
        logic             seq;
        logic [2:0]       op;
        logic [ARG_W-1:0] arg;
    } usr_cmd_t;

    typedef enum logic [1:0] {
        LED_OFF    = 2'd0,
        LED_STATIC = 2'd1,
        LED_BLINK  = 2'd2,
        LED_PULSE  = 2'd3
    } led_mode_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_DECODE = 2'd2
    } fsm_state_e;

    function automatic logic is_led_op(input logic [2:0] op);
        return (op == OP_LED) || (op == OP_BLINK) || (op == OP_PULSE);
    endfunction

endpackage

// File: rtl/usr_reg_cmd_decoder_led_pattern_gen.sv
// LED pattern engine: free-running prescaler tick drives static, blink and
// counted-pulse patterns. A load restarts prescaler and period counter.
module usr_reg_cmd_decoder_led_pattern_gen
    import usr_reg_cmd_decoder_pkg::*;
#(
    parameter int PRESC_W = 16
) (
    input  logic             fpga_clk_in,
    input  logic             fpga_rst,
    input  logic             load,
    input  logic [2:0]       op,
    input  logic [ARG_W-1:0] arg,
    output logic             led_out
);

    led_mode_e          mode_q;
    logic [PRESC_W-1:0] presc_q;
    logic [ARG_W-1:0]   half_q;
    logic [ARG_W-1:0]   per_cnt_q;
    logic [ARG_W-1:0]   pulse_left_q;
    logic               led_q;
    logic               tick;

    assign tick    = (presc_q == '1);
    assign led_out = led_q;

    always_ff @(posedge fpga_clk_in or posedge fpga_rst) begin
        if (fpga_rst) begin
            mode_q       <= LED_OFF;
            presc_q      <= '0;
            half_q       <= ARG_W'(1);
            per_cnt_q    <= '0;
            pulse_left_q <= '0;
            led_q        <= 1'b0;
        end else if (load) begin
            presc_q   <= '0;
            per_cnt_q <= '0;
            case (op)
                OP_LED: begin
                    mode_q <= LED_STATIC;
                    led_q  <= arg[0];
                end
                OP_BLINK: begin
                    mode_q <= LED_BLINK;
                    half_q <= (arg == '0) ? ARG_W'(1) : arg;
                    led_q  <= 1'b1;
                end
                OP_PULSE: begin
                    // A zero-length train also cancels whatever pattern was running.
                    if (arg == '0) begin
                        mode_q <= LED_OFF;
                        led_q  <= 1'b0;
                    end else begin
                        mode_q       <= LED_PULSE;
                        pulse_left_q <= arg;
                        led_q        <= 1'b1;
                    end
                end
                default: ;
            endcase
        end else begin
            presc_q <= presc_q + 1'b1;
            if (tick) begin
                case (mode_q)
                    LED_BLINK: begin
                        if (per_cnt_q == half_q - 1'b1) begin
                            per_cnt_q <= '0;
                            led_q     <= ~led_q;
                        end else begin
                            per_cnt_q <= per_cnt_q + 1'b1;
                        end
                    end
                    LED_PULSE: begin
                        // Each pulse is one tick high, one tick low; the last falling
                        // edge retires the train.
                        if (led_q) begin
                            led_q        <= 1'b0;
                            pulse_left_q <= pulse_left_q - 1'b1;
                            if (pulse_left_q == ARG_W'(1))
                                mode_q <= LED_OFF;
                        end else begin
                            led_q <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: rtl/usr_reg_cmd_decoder.sv
// Fabric-side reader of the MCU user register: resynchronise, deglitch, detect
// seq toggles, execute the command and return the seq bit as acknowledge.
module usr_reg_cmd_decoder
    import usr_reg_cmd_decoder_pkg::*;
#(
    parameter int SYNC_STG   = 2,
    parameter int STABLE_CYC = 4,
    parameter int PRESC_W    = 16
) (
    input  logic             fpga_clk_in,
    input  logic             fpga_rst,
    input  logic [CMD_W-1:0] usr_reg,
    output logic             cmd_ack,
    output logic             cmd_valid,
    output logic [2:0]       cmd_op,
    output logic [7:0]       usr_out,
    output logic             led_out,
    output logic             err_cmd
);

    localparam int CNT_W = $clog2(STABLE_CYC + 1);

    logic [SYNC_STG-1:0][CMD_W-1:0] sync_q;
    usr_cmd_t         sync_val;
    usr_cmd_t         prev_q;
    usr_cmd_t         last_val_q;
    logic             last_seq_q;
    logic [CNT_W-1:0] stab_cnt_q;
    fsm_state_e       state_q;
    fsm_state_e       state_d;
    logic             changed;
    logic             stab_done;
    logic             settle_start;
    logic             accept;
    logic             exec;
    logic             led_load;

    // Bus-wide synchroniser; skew between bits is absorbed by the stability filter.
    always_ff @(posedge fpga_clk_in or posedge fpga_rst) begin
        if (fpga_rst)
            sync_q <= '0;
        else
            sync_q <= {sync_q[SYNC_STG-2:0], usr_reg};
    end

    assign sync_val  = sync_q[SYNC_STG-1];
    assign changed   = (sync_val != last_val_q);
    assign stab_done = (state_q == ST_SETTLE) && (stab_cnt_q == CNT_W'(STABLE_CYC));

    always_ff @(posedge fpga_clk_in or posedge fpga_rst) begin
        if (fpga_rst)
            state_q <= ST_IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (changed) state_d = ST_SETTLE;
            ST_SETTLE: if (stab_done)
                           state_d = (prev_q.seq != last_seq_q) ? ST_DECODE : ST_IDLE;
            ST_DECODE: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        cmd_valid    = 1'b0;
        settle_start = 1'b0;
        accept       = 1'b0;
        exec         = 1'b0;
        case (state_q)
            ST_IDLE:   settle_start = changed;
            ST_SETTLE: begin
                accept = stab_done;
                exec   = stab_done && (prev_q.seq != last_seq_q);
            end
            ST_DECODE: cmd_valid = 1'b1;
            default: ;
        endcase
    end

    // Registers load on the edge into DECODE so they are already visible while
    // cmd_valid is high.
    always_ff @(posedge fpga_clk_in or posedge fpga_rst) begin
        if (fpga_rst) begin
            prev_q     <= '0;
            last_val_q <= '0;
            last_seq_q <= 1'b0;
            stab_cnt_q <= '0;
            cmd_op     <= '0;
            usr_out    <= '0;
            err_cmd    <= 1'b0;
        end else begin
            prev_q <= sync_val;
            if (settle_start)
                stab_cnt_q <= CNT_W'(1);
            else if ((state_q == ST_SETTLE) && !stab_done)
                stab_cnt_q <= (sync_val == prev_q) ? stab_cnt_q + 1'b1 : CNT_W'(1);
            if (accept)
                last_val_q <= prev_q;
            if (exec) begin
                last_seq_q <= prev_q.seq;
                cmd_op     <= prev_q.op;
                case (prev_q.op)
                    OP_NOP:                     err_cmd <= 1'b0;
                    OP_LED, OP_BLINK, OP_PULSE: ;
                    OP_USR:                     usr_out <= prev_q.arg[7:0];
                    default:                    err_cmd <= 1'b1;
                endcase
            end
        end
    end

    assign cmd_ack  = last_seq_q;
    assign led_load = exec && is_led_op(prev_q.op);

    usr_reg_cmd_decoder_led_pattern_gen #(
        .PRESC_W (PRESC_W)
    ) u_led (
        .fpga_clk_in (fpga_clk_in),
        .fpga_rst    (fpga_rst),
        .load        (led_load),
        .op          (prev_q.op),
        .arg         (prev_q.arg),
        .led_out     (led_out)
    );

endmodule

// File: tb/tb_usr_reg_cmd_decoder.sv
// Directed bench for usr_reg_cmd_decoder (SYNC_STG=2, STABLE_CYC=4, PRESC_W=2):
// cycle n is the period after the n-th rising edge following a usr_reg change.
module tb_usr_reg_cmd_decoder;

    logic        fpga_clk_in = 1'b0;
    logic        fpga_rst    = 1'b1;
    logic [15:0] usr_reg     = 16'h0000;
    logic        cmd_ack;
    logic        cmd_valid;
    logic [2:0]  cmd_op;
    logic [7:0]  usr_out;
    logic        led_out;
    logic        err_cmd;

    int tests  = 0;
    int failed = 0;

    usr_reg_cmd_decoder #(
        .SYNC_STG   (2),
        .STABLE_CYC (4),
        .PRESC_W    (2)
    ) dut (
        .fpga_clk_in (fpga_clk_in),
        .fpga_rst    (fpga_rst),
        .usr_reg     (usr_reg),
        .cmd_ack     (cmd_ack),
        .cmd_valid   (cmd_valid),
        .cmd_op      (cmd_op),
        .usr_out     (usr_out),
        .led_out     (led_out),
        .err_cmd     (err_cmd)
    );

    always #20 fpga_clk_in = ~fpga_clk_in;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [13:0] outs();
        return {cmd_ack, cmd_valid, cmd_op, usr_out, led_out, err_cmd};
    endfunction

    // Change usr_reg just after a rising edge (that edge is cycle 0).
    task automatic drive(input logic [15:0] v);
        @(posedge fpga_clk_in);
        #1 usr_reg = v;
    endtask

    // Returns at the falling edge of the cycle after the pulse.
    task automatic wait_valid(input string tag, input int exp_cyc);
        int n;
        n = 0;
        @(negedge fpga_clk_in);
        while (!cmd_valid && n < 40) begin
            n++;
            @(negedge fpga_clk_in);
        end
        check({tag, " latency"}, n, exp_cyc);
        @(negedge fpga_clk_in);
        check({tag, " pulse width"}, cmd_valid, 1'b0);
    endtask

    task automatic count_valid(input int n, output int c);
        c = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge fpga_clk_in);
            if (cmd_valid) c++;
        end
    endtask

    task automatic trace(input int n, output logic [63:0] t);
        t = '0;
        for (int i = 0; i < n; i++) begin
            t[i] = led_out;
            @(negedge fpga_clk_in);
        end
    endtask

    initial begin
        logic [63:0] t;
        logic [63:0] e;
        int          c;

        #5 check("reset outputs", outs(), 14'h0);
        repeat (3) @(posedge fpga_clk_in);
        #1 fpga_rst = 1'b0;
        count_valid(20, c);
        check("idle no valid", c, 0);
        check("idle outputs", outs(), 14'h0);

        // Static LED on, first command uses seq=1
        drive(16'h9001);
        wait_valid("9001", 7);
        check("9001 op", cmd_op, 3'd1);
        check("9001 led", led_out, 1'b1);
        check("9001 ack", cmd_ack, 1'b1);

        // Short glitch that settles back to the already-accepted value
        drive(16'h2002);
        repeat (2) @(posedge fpga_clk_in);
        #1 usr_reg = 16'h9001;
        count_valid(20, c);
        check("glitch no valid", c, 0);
        check("glitch ack", cmd_ack, 1'b1);
        check("glitch led", led_out, 1'b1);

        // Blink, half-period 2 ticks = 8 clocks, high from cycle 7
        drive(16'h2002);
        wait_valid("2002", 7);
        check("2002 op", cmd_op, 3'd2);
        check("2002 ack", cmd_ack, 1'b0);
        trace(24, t);
        e = '0;
        for (int i = 0; i < 24; i++) e[i] = (((i + 1) / 8) % 2) == 0;
        check("blink2 trace", t, e);

        // Three 4-clock pulses (high cycles 7-10, 15-18, 23-26), then dark
        drive(16'hB003);
        wait_valid("B003", 7);
        check("B003 ack", cmd_ack, 1'b1);
        trace(32, t);
        e = '0;
        for (int i = 0; i < 32; i++) e[i] = ((i + 1) < 20) && ((((i + 1) / 4) % 2) == 0);
        check("pulse3 trace", t, e);
        trace(16, t);
        check("pulse3 stays off", t, 64'h0);

        drive(16'h1001);
        wait_valid("1001", 7);
        check("1001 led", led_out, 1'b1);
        check("1001 ack", cmd_ack, 1'b0);

        // Blink command lands in the middle of a pulse train
        drive(16'hB003);
        wait_valid("B003 again", 7);
        repeat (4) @(posedge fpga_clk_in);
        drive(16'h2002);
        wait_valid("2002 abort", 7);
        check("abort op", cmd_op, 3'd2);
        trace(24, t);
        e = '0;
        for (int i = 0; i < 24; i++) e[i] = (((i + 1) / 8) % 2) == 0;
        check("abort blink trace", t, e);

        // Blink with arg=0 behaves as half-period 1 tick
        drive(16'hA000);
        wait_valid("A000", 7);
        trace(16, t);
        e = '0;
        for (int i = 0; i < 16; i++) e[i] = (((i + 1) / 4) % 2) == 0;
        check("blink0 trace", t, e);

        // Pulse with arg=0 switches the LED off at once
        drive(16'h3000);
        wait_valid("3000", 7);
        trace(12, t);
        check("pulse0 off trace", t, 64'h0);

        drive(16'h9001);
        wait_valid("9001 again", 7);
        check("9001 again led", led_out, 1'b1);

        drive(16'h5000);
        wait_valid("5000", 7);
        check("illegal err", err_cmd, 1'b1);
        check("illegal ack", cmd_ack, 1'b0);
        check("illegal op", cmd_op, 3'd5);
        check("illegal led", led_out, 1'b1);

        drive(16'h8000);
        wait_valid("8000", 7);
        check("nop err", err_cmd, 1'b0);
        check("nop ack", cmd_ack, 1'b1);

        drive(16'h40A5);
        wait_valid("40A5", 7);
        check("usr out", usr_out, 8'hA5);
        check("usr ack", cmd_ack, 1'b0);
        check("usr op", cmd_op, 3'd4);

        // Asynchronous reset in the middle of SETTLE
        drive(16'h9001);
        repeat (4) @(posedge fpga_clk_in);
        #5 fpga_rst = 1'b1;
        #1 check("mid-settle reset outputs", outs(), 14'h0);
        repeat (2) @(posedge fpga_clk_in);
        #1 fpga_rst = 1'b0;
        wait_valid("post-reset 9001", 7);
        check("post-reset ack", cmd_ack, 1'b1);
        check("post-reset led", led_out, 1'b1);
        check("post-reset usr_out", usr_out, 8'h00);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
